mdu: RTL
========

Name: mdu

Overview:
- Multi-cycle RV32M multiply/divide unit.
- Acts as the responder on the same `enabled`/`completed` handshake that the execute stage uses with its ALU/FPU.
- Execute pulses `enabled` with the decoded `funct3` and operand values. The unit iterates, raises `completed` and holds `result` until the next request.
- Sits beside `alu`/`fpu` inside execute. Selected when the instruction is RV32M.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- enabled  input  1  one-cycle request pulse; operands valid in the same cycle
- funct3  input  3  op select: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- rs1  input  32  operand A
- rs2  input  32  operand B
- completed  output  1  result valid; level signal
- result  output  32  operation result
- busy  output  1  high in MUL or DIV state

Behaviour:
- Reset (async assert): state IDLE, result = 0, completed = 0, busy = 0, internal counter/accumulators = 0. Reset mid-operation aborts the operation; there is no completion for the aborted op.
- States and transitions:
  - IDLE/DONE -> MUL on `enabled` with funct3[2] = 0.
  - IDLE/DONE -> DIV on `enabled` with funct3[2] = 1.
  - MUL/DIV -> DONE after the last iteration.
  - `enabled` is sampled only in IDLE or DONE. `enabled` in MUL/DIV is a protocol violation: ignored, state and operands unchanged.
- completed = (state == DONE) & !enabled (combinational). It drops in the same cycle a new request arrives and stays high in DONE indefinitely.
- On the accepting edge (E0):
  - Latch |A| and |B| plus sign flags. Signedness per funct3: mulh/div/rem signed both; mulhsu signed A only; mulhu/divu/remu unsigned.
  - Clear counter to 0.
- MUL: radix-2 shift-add on a 64-bit accumulator, one bit per edge, E1..E32. On E32:
  - Negate the 64-bit product if the operand signs differ.
  - Write result: low word for mul, high word for the others.
  - Enter DONE. `completed` is visible in the cycle after E32 (32-cycle latency).
- DIV: restoring division, one quotient bit per edge, E1..E32. On E32:
  - Quotient sign = sA ^ sB; remainder sign = sA.
  - Write quotient (div/divu) or remainder (rem/remu). Enter DONE.
- Special cases, resolved on E1 with DONE after E1 (1-cycle latency):
  - B = 0: quotient = 0xFFFFFFFF, remainder = A.
  - Signed overflow, A = 0x80000000 and B = 0xFFFFFFFF (div/rem only): quotient = 0x80000000, remainder = 0.
- `result` changes only on the completing edge. It holds the previous value during MUL/DIV.
- Back-to-back: `enabled` in DONE starts a new op. `completed` falls combinationally that cycle.
- No exceptions or flags are produced.

Optional Feature:
- MDU_FAST_MUL_EN
  - Defined: multiply ops use a single-cycle combinational 33x33 signed product. Result is written on E1 and DONE after E1 (1-cycle latency). The MUL state is still used for exactly one cycle. Divide is unchanged.
  - Undefined: iterative 32-cycle multiply as above.

Test Plan:
1. rst pulsed mid-DIV (after 10 cycles of divu 100/7) -> completed = 0, result = 0, busy = 0 immediately. A new divu 100/7 afterwards -> result = 14 after 32 cycles.
2. mul rs1 = 0xFFFFFFFD (-3), rs2 = 7 -> completed after 32 cycles, result = 0xFFFFFFEB. Then mulh with the same operands -> 0xFFFFFFFF. mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
3. Signed div and rem:
   - div -20/6 -> 0xFFFFFFFD (-3).
   - rem -20/6 -> 0xFFFFFFFE (-2).
   - divu 0x80000000/3 -> 0x2AAAAAAA.
4. Boundary cases, each completing after 1 cycle:
   - div 5/0 -> 0xFFFFFFFF.
   - remu 5/0 -> 5.
   - div 0x80000000/0xFFFFFFFF -> 0x80000000.
   - rem of the same operands -> 0.
5. `enabled` pulsed again at cycle 5 of a mul 6x7 -> ignored; result = 42 at cycle 32. Then `enabled` held high in DONE -> completed reads 0 in that cycle, and the new op is accepted.
6. With MDU_FAST_MUL_EN defined: mulhsu 0xFFFFFFFF x 0xFFFFFFFF -> completed 1 cycle after the request, result = 0xFFFFFFFF. divu latency is unchanged at 32.

Source files
------------

// File: rtl/mdu.sv
// RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide, 32 iterations each (1 cycle for div-by-zero/overflow).
// Requests arriving while busy are ignored; result holds in DONE. Define MDU_FAST_MUL_EN for a single-cycle multiply.
module mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enabled,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   output logic             completed,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t      state;
   logic [2:0]  op;
   logic        sgn_a;
   logic        sgn_b;
   logic [31:0] abs_b;
   logic [63:0] acc;
   logic [4:0]  cnt;
   logic        b_zero;
   logic        ovf;

   // Operand conditioning for the accepting edge
   logic        a_signed_op;
   logic        b_signed_op;
   logic        neg_a_in;
   logic        neg_b_in;
   logic [31:0] abs_a_in;
   logic [31:0] abs_b_in;

   assign a_signed_op = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
   assign b_signed_op = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
   assign neg_a_in    = a_signed_op && rs1[31];
   assign neg_b_in    = b_signed_op && rs2[31];
   assign abs_a_in    = neg_a_in ? (32'd0 - rs1) : rs1;
   assign abs_b_in    = neg_b_in ? (32'd0 - rs2) : rs2;

   // Multiply datapath
   logic [31:0] mul_res;
`ifdef MDU_FAST_MUL_EN
   logic signed [32:0] fast_a;
   logic signed [32:0] fast_b;
   logic signed [63:0] fast_p;

   assign fast_a  = sgn_a ? -$signed({1'b0, acc[31:0]}) : $signed({1'b0, acc[31:0]});
   assign fast_b  = sgn_b ? -$signed({1'b0, abs_b})     : $signed({1'b0, abs_b});
   assign fast_p  = fast_a * fast_b;
   assign mul_res = (op[1:0] == 2'b00) ? fast_p[31:0] : fast_p[63:32];
`else
   logic [32:0] mul_sum;
   logic [63:0] mul_acc_n;
   logic [63:0] mul_prod;

   assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, abs_b} : 33'd0);
   assign mul_acc_n = {mul_sum, acc[31:1]};
   assign mul_prod  = (sgn_a ^ sgn_b) ? (64'd0 - mul_acc_n) : mul_acc_n;
   assign mul_res   = (op[1:0] == 2'b00) ? mul_prod[31:0] : mul_prod[63:32];
`endif

   // Restoring divide: acc[63:32] is the partial remainder, acc[31:0] shifts dividend out / quotient in
   logic [32:0] rem_sh;
   logic        div_ge;
   logic [31:0] rem_n;
   logic [31:0] quo_n;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;
   logic [31:0] div_res;
   logic [31:0] a_orig;
   logic [31:0] spec_res;

   assign rem_sh   = {acc[63:32], acc[31]};
   assign div_ge   = rem_sh >= {1'b0, abs_b};
   assign rem_n    = div_ge ? (rem_sh[31:0] - abs_b) : rem_sh[31:0];
   assign quo_n    = {acc[30:0], div_ge};
   assign quo_fix  = (sgn_a ^ sgn_b) ? (32'd0 - quo_n) : quo_n;
   assign rem_fix  = sgn_a ? (32'd0 - rem_n) : rem_n;
   assign div_res  = op[1] ? rem_fix : quo_fix;
   assign a_orig   = sgn_a ? (32'd0 - acc[31:0]) : acc[31:0];
   assign spec_res = b_zero ? (op[1] ? a_orig : 32'hFFFF_FFFF)
                            : (op[1] ? 32'd0  : 32'h8000_0000);

   assign completed = (state == S_DONE) && !enabled;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         op     <= 3'd0;
         sgn_a  <= 1'b0;
         sgn_b  <= 1'b0;
         abs_b  <= 32'd0;
         acc    <= 64'd0;
         cnt    <= 5'd0;
         b_zero <= 1'b0;
         ovf    <= 1'b0;
         result <= 32'd0;
         busy   <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (enabled) begin
                  op     <= funct3;
                  sgn_a  <= neg_a_in;
                  sgn_b  <= neg_b_in;
                  abs_b  <= abs_b_in;
                  acc    <= {32'd0, abs_a_in};
                  cnt    <= 5'd0;
                  b_zero <= (rs2 == 32'd0);
                  ovf    <= funct3[2] && !funct3[0] &&
                            (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
                  state  <= funct3[2] ? S_DIV : S_MUL;
                  busy   <= 1'b1;
               end
            end
            S_MUL: begin
`ifdef MDU_FAST_MUL_EN
               result <= mul_res;
               state  <= S_DONE;
               busy   <= 1'b0;
`else
               acc <= mul_acc_n;
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  result <= mul_res;
                  state  <= S_DONE;
                  busy   <= 1'b0;
               end
`endif
            end
            S_DIV: begin
               if (cnt == 5'd0 && (b_zero || ovf)) begin
                  result <= spec_res;
                  state  <= S_DONE;
                  busy   <= 1'b0;
               end else begin
                  acc <= {rem_n, quo_n};
                  cnt <= cnt + 5'd1;
                  if (cnt == 5'd31) begin
                     result <= div_res;
                     state  <= S_DONE;
                     busy   <= 1'b0;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
